hash_store_matcher: RTL and testbench
=====================================

Name: hash_store_matcher

Overview:
- Target-hash database and comparator downstream of the MD4 block in the NT-hash cracker.
- Loading phase: the cracker controller presents 128-bit target hashes one at a time; the block stores them.
- Processing phase: each computed, byte-swapped MD4 digest is presented; the block scans the stored hashes one per cycle and reports hit or miss.
- Handshake is a multi-cycle trigger pulse in, with a level-sensitive result-ready out.

Parameters:
- HASH_COUNT, 8, number of target-hash slots (1..256).
- HASH_W, 128, hash width in bits.
- IDX_W, $clog2(HASH_COUNT) (1 when HASH_COUNT is 1), slot index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- newrdy  in  1  store request; level held ≥1 cycle, acted on at its rising edge.
- checkrdy  in  1  check request; level held ≥1 cycle, acted on at its rising edge.
- hash  in  HASH_W  hash to store or check; must be stable from the request edge until resultrdy is high.
- resultrdy  out  1  1 = idle / last operation complete.
- matchfound  out  1  result of the last check; valid while resultrdy=1.
- match_index  out  IDX_W  slot that matched; valid when matchfound=1.
- count  out  IDX_W+1  number of stored hashes.
- full  out  1  count == HASH_COUNT.
- overflow  out  1  sticky; a store was attempted while full.
- req_dropped  out  1  sticky; a request edge arrived while busy, or was the losing side of a simultaneous pair.

Behaviour:
- Reset (async): all slots 0, count=0, resultrdy=1, matchfound=0, match_index=0, overflow=0, req_dropped=0, edge-history flops=0, state IDLE.
- Edge detect: registered previous sample of newrdy and checkrdy. A rise is current=1 and previous=0, both sampled at the same clk edge.
- States: IDLE, STORE, SCAN.
- IDLE, rise on newrdy at edge E:
  - resultrdy<=0, matchfound<=0, go to STORE.
  - If checkrdy also rises at E, the check is discarded and req_dropped<=1 (store wins).
- STORE (edge E+1):
  - If count<HASH_COUNT: slot[count]<=hash, count<=count+1.
  - Else: no write, overflow<=1.
  - In both cases resultrdy<=1, return to IDLE. Latency is 2 edges.
- IDLE, rise on checkrdy only at edge E:
  - resultrdy<=0, matchfound<=0, idx<=0.
  - If count==0: go to IDLE and set resultrdy<=1 at E+1 with matchfound=0.
  - Else go to SCAN.
- SCAN (edge E+1+i compares slot[i]):
  - Equal: matchfound<=1, match_index<=i, resultrdy<=1, go to IDLE. Early exit.
  - Not equal and i==count-1: matchfound<=0, resultrdy<=1, go to IDLE.
  - Otherwise idx<=idx+1.
  - Worst-case latency is count+1 edges. Only indices below count are compared; unwritten slots never match.
- Busy rule: any rise while in STORE or SCAN is ignored and sets req_dropped<=1. The current operation continues unaffected.
- matchfound and match_index hold their values until the next accepted request edge.
- resultrdy is already 0 one edge after the request rises. A controller that holds the trigger 2 cycles, drops it, then waits for resultrdy=1 therefore never sees a stale ready.
- Duplicate stored hashes are allowed; the lowest matching index is reported.
- Reset asserted mid-store or mid-scan: immediate return to the reset values; the table is emptied.
- count never exceeds HASH_COUNT; it does not wrap.

Decomposition:
- Shared package ntcrack_pkg holds:
  - HASH_W=128;
  - the state enum {IDLE, STORE, SCAN};
  - the default HASH_COUNT constant, shared with the cracker top.
- One sub-module, rise_detect: 1-bit registered previous sample and a rise output, with async active-high reset. It is instantiated twice, for newrdy and checkrdy.
- Slot storage and comparison stay inline. The comparator is a single HASH_W-bit equality on slot[idx].

Test Plan:
- Store 3 hashes (0x31D6CFE0D16AE931B73C59D7E0C089C0, 0x8846F7EAEE8FB117AD06BDD830B7586C, 0xA4F49C406510BDCAB6824EE7C30FD852), each with a 2-cycle newrdy pulse -> resultrdy low 1 edge after each rise and high 2 edges after it; count=3; full=0.
- Check 0x8846F7EAEE8FB117AD06BDD830B7586C -> resultrdy low at E, high at E+2; matchfound=1; match_index=1.
- Check 0x00000000000000000000000000000000 against the 3 stored hashes -> resultrdy high at E+3; matchfound=0.
- Check with an empty table after reset -> resultrdy high at E+1; matchfound=0.
- HASH_COUNT=2: store 3 hashes -> count=2, full=1, overflow=1, third hash not matchable. Then a check rise during a scan -> req_dropped=1 and the first check's result is still correct.
- newrdy and checkrdy rise at the same edge -> hash stored, req_dropped=1. Then assert reset during a SCAN -> resultrdy=1, count=0, matchfound=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ntcrack_pkg.sv
// ntcrack_pkg: definitions shared across the NT-hash cracker.
//   HASH_W             - width of an MD4/NT hash in bits
//   DEFAULT_HASH_COUNT - default number of target-hash slots (shared with cracker top)
//   state_t            - hash_store_matcher controller states
//   idx_width()        - slot index width for a given slot count (never below 1)
package ntcrack_pkg;

  localparam int HASH_W             = 128;
  localparam int DEFAULT_HASH_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    SCAN
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_store_matcher_if.sv
// hash_store_matcher_if: request/result bundle between the cracker controller
// (master) and the target-hash store/matcher (slave).
//   newrdy, checkrdy  master->slave  store / check request levels
//   hash              master->slave  hash to store or check
//   resultrdy         slave->master  1 = idle / last operation complete
//   matchfound        slave->master  result of last check
//   match_index       slave->master  lowest matching slot
//   count, full       slave->master  table occupancy
//   overflow          slave->master  sticky: store attempted while full
//   req_dropped       slave->master  sticky: request edge ignored
interface hash_store_matcher_if #(
  parameter int HASH_COUNT = ntcrack_pkg::DEFAULT_HASH_COUNT,
  parameter int HASH_W     = ntcrack_pkg::HASH_W
);
  import ntcrack_pkg::*;

  localparam int IDX_W = idx_width(HASH_COUNT);

  logic              newrdy;
  logic              checkrdy;
  logic [HASH_W-1:0] hash;
  logic              resultrdy;
  logic              matchfound;
  logic [IDX_W-1:0]  match_index;
  logic [IDX_W:0]    count;
  logic              full;
  logic              overflow;
  logic              req_dropped;

  modport master (
    output newrdy, checkrdy, hash,
    input  resultrdy, matchfound, match_index, count, full, overflow, req_dropped
  );

  modport slave (
    input  newrdy, checkrdy, hash,
    output resultrdy, matchfound, match_index, count, full, overflow, req_dropped
  );

endinterface

// File: rtl/rise_detect.sv
// rise_detect: registered previous sample of a level input; rise is high
// while the current level is 1 and the previous clock's sample was 0.
//   clk   in  system clock
//   reset in  asynchronous active-high reset (history cleared to 0)
//   d     in  level to watch
//   rise  out d & ~previous(d)
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_prev <= 1'b0;
    else       d_prev <= d;
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/hash_store_matcher.sv
// hash_store_matcher: target-hash table and comparator behind the MD4 block.
// A rising newrdy appends the presented hash to the table; a rising checkrdy
// scans stored slots one per cycle (lowest index first) and reports hit/miss.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset; empties the table
//   bus    slave modport of hash_store_matcher_if (requests, hash, results)
module hash_store_matcher #(
  parameter int HASH_COUNT = ntcrack_pkg::DEFAULT_HASH_COUNT,
  parameter int HASH_W     = ntcrack_pkg::HASH_W
) (
  input logic                 clk,
  input logic                 reset,
  hash_store_matcher_if.slave bus
);
  import ntcrack_pkg::*;

  localparam int             IDX_W    = idx_width(HASH_COUNT);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(HASH_COUNT);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  state_t            state;
  logic              new_rise;
  logic              chk_rise;
  logic [HASH_W-1:0] slots [HASH_COUNT];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    count_r;
  logic              resultrdy_r;
  logic              matchfound_r;
  logic [IDX_W-1:0]  match_index_r;
  logic              overflow_r;
  logic              req_dropped_r;
  logic              last_slot;

  rise_detect u_new_rise (.clk(clk), .reset(reset), .d(bus.newrdy),   .rise(new_rise));
  rise_detect u_chk_rise (.clk(clk), .reset(reset), .d(bus.checkrdy), .rise(chk_rise));

  // Only meaningful when count_r != 0; the SCAN branch checks that first.
  assign last_slot = ({1'b0, idx} == (count_r - CNT_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      count_r       <= '0;
      resultrdy_r   <= 1'b1;
      matchfound_r  <= 1'b0;
      match_index_r <= '0;
      overflow_r    <= 1'b0;
      req_dropped_r <= 1'b0;
      for (int i = 0; i < HASH_COUNT; i++) slots[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (new_rise) begin
            // Store wins a simultaneous pair; the check is discarded.
            resultrdy_r  <= 1'b0;
            matchfound_r <= 1'b0;
            state        <= STORE;
            if (chk_rise) req_dropped_r <= 1'b1;
          end else if (chk_rise) begin
            // An empty table still passes through SCAN for one edge so the
            // miss is reported at E+1 like any other completion.
            resultrdy_r  <= 1'b0;
            matchfound_r <= 1'b0;
            idx          <= '0;
            state        <= SCAN;
          end
        end
        STORE: begin
          if (new_rise || chk_rise) req_dropped_r <= 1'b1;
          if (count_r < FULL_CNT) begin
            slots[count_r[IDX_W-1:0]] <= bus.hash;
            count_r                   <= count_r + CNT_ONE;
          end else begin
            overflow_r <= 1'b1;
          end
          resultrdy_r <= 1'b1;
          state       <= IDLE;
        end
        SCAN: begin
          if (new_rise || chk_rise) req_dropped_r <= 1'b1;
          if (count_r == '0) begin
            matchfound_r <= 1'b0;
            resultrdy_r  <= 1'b1;
            state        <= IDLE;
          end else if (slots[idx] == bus.hash) begin
            matchfound_r  <= 1'b1;
            match_index_r <= idx;
            resultrdy_r   <= 1'b1;
            state         <= IDLE;
          end else if (last_slot) begin
            matchfound_r <= 1'b0;
            resultrdy_r  <= 1'b1;
            state        <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resultrdy   = resultrdy_r;
  assign bus.matchfound  = matchfound_r;
  assign bus.match_index = match_index_r;
  assign bus.count       = count_r;
  assign bus.full        = (count_r == FULL_CNT);
  assign bus.overflow    = overflow_r;
  assign bus.req_dropped = req_dropped_r;

endmodule

// File: tb/tb_hash_store_matcher.sv
// tb_hash_store_matcher: bench for hash_store_matcher with an 8-slot and a
// 2-slot instance. Directed table vectors, hand-written corner sequences and
// randomized operations against a queue-based reference model.
module tb_hash_store_matcher;
  import ntcrack_pkg::*;

  localparam logic [127:0] HA = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
  localparam logic [127:0] HB = 128'h8846F7EAEE8FB117AD06BDD830B7586C;
  localparam logic [127:0] HC = 128'hA4F49C406510BDCAB6824EE7C30FD852;

  logic clk;
  logic rst8, rst2;

  hash_store_matcher_if #(.HASH_COUNT(8)) bus8();
  hash_store_matcher_if #(.HASH_COUNT(2)) bus2();

  hash_store_matcher #(.HASH_COUNT(8)) dut8 (.clk(clk), .reset(rst8), .bus(bus8));
  hash_store_matcher #(.HASH_COUNT(2)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit rdy;
    bit mf;
    bit full;
    bit ovf;
    bit drop;
    int idx;
    int cnt;
  } obs_t;

  typedef struct {
    bit           st;
    logic [127:0] h;
    int           hold;
    bit           mf;
    int           idx;
    int           cnt;
    int           lat;
    bit           full;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 8) begin
      o.rdy = bus8.resultrdy; o.mf = bus8.matchfound; o.full = bus8.full;
      o.ovf = bus8.overflow;  o.drop = bus8.req_dropped;
      o.idx = int'(bus8.match_index); o.cnt = int'(bus8.count);
    end else begin
      o.rdy = bus2.resultrdy; o.mf = bus2.matchfound; o.full = bus2.full;
      o.ovf = bus2.overflow;  o.drop = bus2.req_dropped;
      o.idx = int'(bus2.match_index); o.cnt = int'(bus2.count);
    end
    return o;
  endfunction

  task automatic drive(input int sel, input bit nr, input bit cr, input logic [127:0] h);
    if (sel == 8) begin
      bus8.newrdy = nr; bus8.checkrdy = cr; bus8.hash = h;
    end else begin
      bus2.newrdy = nr; bus2.checkrdy = cr; bus2.hash = h;
    end
  endtask

  task automatic set_rst(input int sel, input bit v);
    if (sel == 8) rst8 = v;
    else          rst2 = v;
  endtask

  task automatic do_reset(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, '0);
    set_rst(sel, 1'b1);
    @(negedge clk);
    set_rst(sel, 1'b0);
  endtask

  // lat = j where E+j is the first edge after which resultrdy reads 1
  // (E = edge at which the request rise is seen); -1 on timeout.
  task automatic op(input int sel, input bit st, input logic [127:0] h, input int hold,
                    output int lat, output bit low_e);
    obs_t o;
    @(negedge clk);
    drive(sel, st, !st, h);
    @(posedge clk);
    @(negedge clk);
    o = sample(sel);
    low_e = !o.rdy;
    if (hold <= 1) drive(sel, 1'b0, 1'b0, h);
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j + 1 >= hold) drive(sel, 1'b0, 1'b0, h);
      if (lat < 0) begin
        o = sample(sel);
        if (o.rdy) lat = j;
      end
      if (lat >= 0 && j + 1 >= hold) break;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  vec_t         tbl [10];
  obs_t         o;
  int           lat;
  bit           low_e;
  logic [127:0] model_q [$];
  logic [127:0] pool [6];
  bit           m_ovf;

  initial begin
    tbl[0] = '{1'b0, HB,      2, 1'b0, 0, 0, 1, 1'b0};
    tbl[1] = '{1'b1, HA,      2, 1'b0, 0, 1, 1, 1'b0};
    tbl[2] = '{1'b1, HB,      2, 1'b0, 0, 2, 1, 1'b0};
    tbl[3] = '{1'b1, HC,      2, 1'b0, 0, 3, 1, 1'b0};
    tbl[4] = '{1'b0, HB,      2, 1'b1, 1, 3, 2, 1'b0};
    tbl[5] = '{1'b0, 128'h0,  2, 1'b0, 0, 3, 3, 1'b0};
    tbl[6] = '{1'b1, HB,      1, 1'b0, 0, 4, 1, 1'b0};
    tbl[7] = '{1'b0, HB,      2, 1'b1, 1, 4, 2, 1'b0};
    tbl[8] = '{1'b0, HC,      3, 1'b1, 2, 4, 3, 1'b0};
    tbl[9] = '{1'b0, HA,      1, 1'b1, 0, 4, 1, 1'b0};

    rst8 = 1'b1; rst2 = 1'b1;
    drive(8, 1'b0, 1'b0, '0);
    drive(2, 1'b0, 1'b0, '0);
    #1;
    o = sample(8);
    chk("reset_resultrdy", o.rdy, 1);
    chk("reset_matchfound", o.mf, 0);
    chk("reset_match_index", o.idx, 0);
    chk("reset_count", o.cnt, 0);
    chk("reset_full", o.full, 0);
    chk("reset_overflow", o.ovf, 0);
    chk("reset_req_dropped", o.drop, 0);
    @(negedge clk);
    rst8 = 1'b0; rst2 = 1'b0;

    // Directed table on the 8-slot instance
    for (int i = 0; i < 10; i++) begin
      op(8, tbl[i].st, tbl[i].h, tbl[i].hold, lat, low_e);
      o = sample(8);
      chk($sformatf("tbl%0d_low_at_E", i), low_e, 1);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_matchfound", i), o.mf, tbl[i].mf);
      if (tbl[i].mf) chk($sformatf("tbl%0d_match_index", i), o.idx, tbl[i].idx);
      chk($sformatf("tbl%0d_count", i), o.cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), o.full, tbl[i].full);
      chk($sformatf("tbl%0d_overflow", i), o.ovf, 0);
      chk($sformatf("tbl%0d_req_dropped", i), o.drop, 0);
    end

    // 2-slot instance: overflow, then a check rise during a scan
    op(2, 1'b1, HA, 2, lat, low_e);
    o = sample(2);
    chk("h2_store0_count", o.cnt, 1);
    chk("h2_store0_full", o.full, 0);
    op(2, 1'b1, HB, 2, lat, low_e);
    o = sample(2);
    chk("h2_store1_count", o.cnt, 2);
    chk("h2_store1_full", o.full, 1);
    chk("h2_store1_overflow", o.ovf, 0);
    op(2, 1'b1, HC, 2, lat, low_e);
    o = sample(2);
    chk("h2_store2_latency", lat, 1);
    chk("h2_store2_count", o.cnt, 2);
    chk("h2_store2_full", o.full, 1);
    chk("h2_store2_overflow", o.ovf, 1);
    op(2, 1'b0, HC, 2, lat, low_e);
    o = sample(2);
    chk("h2_check_lost_latency", lat, 2);
    chk("h2_check_lost_matchfound", o.mf, 0);
    op(2, 1'b0, HA, 2, lat, low_e);
    o = sample(2);
    chk("h2_check_a_latency", lat, 1);
    chk("h2_check_a_matchfound", o.mf, 1);
    chk("h2_check_a_index", o.idx, 0);

    @(negedge clk);
    drive(2, 1'b0, 1'b1, HB);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, HB);
    @(posedge clk);
    @(negedge clk);
    o = sample(2);
    chk("h2_busy_resultrdy", o.rdy, 0);
    chk("h2_busy_drop_before", o.drop, 0);
    drive(2, 1'b0, 1'b1, HB);
    @(posedge clk);
    @(negedge clk);
    o = sample(2);
    chk("h2_busy_done", o.rdy, 1);
    chk("h2_busy_matchfound", o.mf, 1);
    chk("h2_busy_index", o.idx, 1);
    chk("h2_busy_req_dropped", o.drop, 1);
    drive(2, 1'b0, 1'b0, HB);

    // Simultaneous store/check rise: store wins
    do_reset(8);
    @(negedge clk);
    drive(8, 1'b1, 1'b1, HC);
    @(posedge clk);
    @(negedge clk);
    o = sample(8);
    chk("sim_low_at_E", o.rdy, 0);
    drive(8, 1'b0, 1'b0, HC);
    @(posedge clk);
    @(negedge clk);
    o = sample(8);
    chk("sim_resultrdy", o.rdy, 1);
    chk("sim_count", o.cnt, 1);
    chk("sim_req_dropped", o.drop, 1);
    chk("sim_matchfound", o.mf, 0);
    op(8, 1'b0, HC, 2, lat, low_e);
    o = sample(8);
    chk("sim_stored_hit", o.mf, 1);
    chk("sim_stored_index", o.idx, 0);
    op(8, 1'b1, HA, 2, lat, low_e);

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    drive(8, 1'b0, 1'b1, 128'h5);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 128'h5);
    @(posedge clk);
    @(negedge clk);
    o = sample(8);
    chk("rst_scan_busy", o.rdy, 0);
    #1 rst8 = 1'b1;
    #1;
    o = sample(8);
    chk("rst_scan_resultrdy", o.rdy, 1);
    chk("rst_scan_count", o.cnt, 0);
    chk("rst_scan_matchfound", o.mf, 0);
    chk("rst_scan_req_dropped", o.drop, 0);
    @(negedge clk);
    rst8 = 1'b0;
    op(8, 1'b0, HC, 2, lat, low_e);
    o = sample(8);
    chk("rst_empty_latency", lat, 1);
    chk("rst_empty_matchfound", o.mf, 0);

    // Randomized operations against a queue model
    do_reset(8);
    model_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < 6; i++) pool[i] = rand128();
    for (int n = 0; n < 80; n++) begin
      bit           st;
      logic [127:0] h;
      int           hold, e_lat, e_idx;
      bit           e_mf;
      st   = ($urandom_range(0, 1) == 1);
      h    = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 5)] : rand128();
      hold = $urandom_range(1, 3);
      op(8, st, h, hold, lat, low_e);
      e_mf = 1'b0; e_idx = 0;
      if (st) begin
        if (model_q.size() < 8) model_q.push_back(h);
        else                    m_ovf = 1'b1;
        e_lat = 1;
      end else begin
        foreach (model_q[k]) if (!e_mf && model_q[k] == h) begin e_mf = 1'b1; e_idx = k; end
        e_lat = e_mf ? e_idx + 1 : ((model_q.size() == 0) ? 1 : model_q.size());
      end
      o = sample(8);
      chk($sformatf("rnd%0d_latency", n), lat, e_lat);
      chk($sformatf("rnd%0d_matchfound", n), o.mf, e_mf);
      if (e_mf) chk($sformatf("rnd%0d_index", n), o.idx, e_idx);
      chk($sformatf("rnd%0d_count", n), o.cnt, model_q.size());
      chk($sformatf("rnd%0d_full", n), o.full, model_q.size() == 8);
      chk($sformatf("rnd%0d_overflow", n), o.ovf, m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
